// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: o = i0 - i1 - bin, LSB first, one full-subtractor step per clock.
// Optional overflow flag is built only when SERIAL_SUB_OVF_EN is defined; otherwise ovf is tied to 0.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] o,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);

    // States: IDLE waits for start | SHIFT processes one bit per clock | DONE pulses done, may relaunch
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_o;
    logic [CW-1:0]    r_cnt;
    logic             r_borrow;
    logic             r_busy;
    logic             r_done;
    logic             r_bout;

    logic             w_d;
    logic             w_borrow_nxt;
    logic             w_last;

    assign w_d          = r_a[0] ^ r_b[0] ^ r_borrow;
    assign w_borrow_nxt = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_borrow);
    assign w_last       = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_r      <= '0;
            r_o      <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_bout   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a      <= i0;
                        r_b      <= i1;
                        r_borrow <= bin;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_SHIFT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_borrow <= w_borrow_nxt;
                    r_r      <= {w_d, r_r[WIDTH-1:1]};
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_o     <= {w_d, r_r[WIDTH-1:1]};
                        r_bout  <= w_borrow_nxt;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic r_ovf;

    // On the last step r_borrow is the borrow into the MSB
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (r_state == S_SHIFT && w_last) begin
            r_ovf <= w_borrow_nxt ^ r_borrow;
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign busy = r_busy;
    assign done = r_done;
    assign o    = r_o;
    assign bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed test-plan cases, held-start relaunch,
// mid-operation reset, exhaustive back-to-back sweep and random operations against an arithmetic model.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] i0;
    logic [W-1:0] i1;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] o;
    logic         bout;
    logic         ovf;

    typedef struct packed {
        logic [W:0] res;
        logic       ovf;
    } exp_t;

    exp_t         q[$];
    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] last_o = '0;
    logic         last_bout = 1'b0;
    logic         last_ovf = 1'b0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .i0   (i0),
        .i1   (i1),
        .bin  (bin),
        .busy (busy),
        .done (done),
        .o    (o),
        .bout (bout),
        .ovf  (ovf)
    );

    function automatic logic [W:0] exp_res(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        return {1'b0, a} - {1'b0, b} - {{W{1'b0}}, c};
    endfunction

    function automatic logic exp_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int s;
        s = int'($signed(a)) - int'($signed(b)) - int'(c);
`ifdef SERIAL_SUB_OVF_EN
        return (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
`else
        return (s != s);
`endif
    endfunction

    function automatic exp_t mk_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        exp_t e;
        e.res = exp_res(a, b, c);
        e.ovf = exp_ovf(a, b, c);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic scramble();
        i0  = W'($urandom());
        i1  = W'($urandom());
        bin = 1'($urandom());
    endtask

    // Called at a negedge: if a completion is visible, compare it against the oldest pending operation
    task automatic service(input string tag);
        exp_t e;
        if (done) begin
            if (q.size() == 0) begin
                check({tag, "_unexpected_done"}, q.size(), 1);
            end else begin
                e = q.pop_front();
                check({tag, "_diff"}, {bout, o}, e.res);
                check({tag, "_ovf"}, ovf, e.ovf);
                last_o    = e.res[W-1:0];
                last_bout = e.res[W];
                last_ovf  = e.ovf;
            end
        end
    endtask

    // Single operation from IDLE, checking latency, busy width, held outputs and the done pulse width
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int   n;
        int   nb;
        logic stable;
        exp_t e;
        e      = mk_exp(a, b, c);
        i0     = a;
        i1     = b;
        bin    = c;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        scramble();
        n      = 1;
        nb     = 0;
        stable = 1'b1;
        while (!done && n < 4 * W) begin
            if (busy) nb++;
            if (o !== last_o || bout !== last_bout || ovf !== last_ovf) stable = 1'b0;
            @(negedge clk);
            scramble();
            n++;
        end
        check({tag, "_latency"}, n, W + 1);
        check({tag, "_busy_cycles"}, nb, W);
        check({tag, "_held"}, stable, 1'b1);
        check({tag, "_busy_at_done"}, busy, 1'b0);
        check({tag, "_diff"}, {bout, o}, e.res);
        check({tag, "_ovf"}, ovf, e.ovf);
        last_o    = e.res[W-1:0];
        last_bout = e.res[W];
        last_ovf  = e.ovf;
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 1'b0);
    endtask

    initial begin
        int   guard;
        int   idx;
        int   ndone;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;

        reset = 1'b1;
        start = 1'b0;
        i0    = '0;
        i1    = '0;
        bin   = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        i0    = 4'b0111;
        i1    = 4'b0001;
        @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_out", {ovf, bout, o}, '0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("reset_wins_over_start", busy, 1'b0);

        run_op("tp_5m3", 4'b0101, 4'b0011, 1'b0);
        check("tp_5m3_const", {ovf, bout, o}, 6'b000010);
        run_op("tp_3m5", 4'b0011, 4'b0101, 1'b0);
        check("tp_3m5_const", {bout, o}, 5'b11110);
        run_op("tp_0m0b", 4'b0000, 4'b0000, 1'b1);
        check("tp_0m0b_const", {bout, o}, 5'b11111);
        run_op("tp_ovf", 4'b1000, 4'b0001, 1'b0);
        check("tp_ovf_const_o", {bout, o}, 5'b00111);
`ifdef SERIAL_SUB_OVF_EN
        check("tp_ovf_flag", ovf, 1'b1);
`else
        check("tp_ovf_flag", ovf, 1'b0);
`endif

        // Start held high for 10 cycles with operands changing every cycle
        i0    = 4'b0110;
        i1    = 4'b0010;
        bin   = 1'b0;
        start = 1'b1;
        q.push_back(mk_exp(4'b0110, 4'b0010, 1'b0));
        ndone = 0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (done) begin
                if (ndone == 0) check("hold_first_o", o, 4'b0100);
                ndone++;
            end
            service("hold");
            a = W'($urandom());
            b = W'($urandom());
            c = 1'($urandom());
            i0  = a;
            i1  = b;
            bin = c;
            if (cyc == 10) start = 1'b0;
            else if (done) q.push_back(mk_exp(a, b, c));
        end
        check("hold_done_count", ndone, 2);
        repeat (W + 2) begin
            @(negedge clk);
            service("hold_drain");
        end
        check("hold_pending", q.size(), 0);
        check("hold_idle", busy, 1'b0);

        // Reset during the second SHIFT cycle abandons the operation
        run_op("pre_rst", 4'b1001, 4'b0010, 1'b0);
        i0    = 4'b1010;
        i1    = 4'b0011;
        bin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_done", done, 1'b0);
        check("rst_mid_out", {ovf, bout, o}, '0);
        last_o    = '0;
        last_bout = 1'b0;
        last_ovf  = 1'b0;
        ndone = 0;
        repeat (W + 3) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("rst_mid_no_done", ndone, 0);
        run_op("post_rst", 4'b1111, 4'b0001, 1'b0);
        check("post_rst_const", {bout, o}, 5'b01110);

        // Exhaustive sweep, each operation launched from the previous DONE cycle
        idx   = 0;
        i0    = 4'b0000;
        i1    = 4'b0000;
        bin   = 1'b0;
        start = 1'b1;
        q.push_back(mk_exp(4'b0000, 4'b0000, 1'b0));
        idx   = 1;
        guard = 0;
        while (q.size() > 0 && guard < 512 * (W + 1) + 50) begin
            @(negedge clk);
            guard++;
            if (done) begin
                service("sweep");
                if (idx < 512) begin
                    a = W'(idx >> 5);
                    b = W'(idx >> 1);
                    c = 1'(idx);
                    i0  = a;
                    i1  = b;
                    bin = c;
                    q.push_back(mk_exp(a, b, c));
                    idx++;
                end else begin
                    start = 1'b0;
                end
            end else begin
                scramble();
            end
        end
        start = 1'b0;
        check("sweep_issued", idx, 512);
        check("sweep_pending", q.size(), 0);
        @(negedge clk);

        for (int k = 0; k < 20; k++) begin
            run_op("rand", W'($urandom()), W'($urandom()), 1'($urandom()));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
